// File: rtl/pipeline_ctrl_pkg.sv
// Shared codes for the pipeline hazard/sequencing controller: register-address width,
// PC source selects and controller state encoding.
package pipeline_ctrl_pkg;

    localparam int XADDR = 5;

    localparam logic [1:0] PC_SEL_SEQ  = 2'b00;
    localparam logic [1:0] PC_SEL_BR   = 2'b01;
    localparam logic [1:0] PC_SEL_TRAP = 2'b10;
    localparam logic [1:0] PC_SEL_MRET = 2'b11;

    typedef enum logic [1:0] {
        CTRL_RUN      = 2'b00,
        CTRL_MEM_WAIT = 2'b01,
        CTRL_REDIRECT = 2'b10
    } ctrl_state_e;

    // A source operand depends on rd only if it is actually read and names the same register.
    function automatic logic src_hit(input logic used, input logic [XADDR-1:0] src,
                                     input logic [XADDR-1:0] rd);
        return used & (src == rd);
    endfunction

endpackage

// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller: load-use bubbles, data-memory wait freeze,
// wrong-path squash on branch/trap/mret and PC source selection.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int MAX_MEM_WAIT = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [XADDR-1:0] i_rs1_addr_id,
    input  logic [XADDR-1:0] i_rs2_addr_id,
    input  logic             i_rs1_used_id,
    input  logic             i_rs2_used_id,
    input  logic [XADDR-1:0] i_rd_addr_ex,
    input  logic             i_ex_is_load,
    input  logic             i_ex_wr_en,
    input  logic             i_branch_taken,
    input  logic             i_mem_req,
    input  logic             i_mem_ack,
    input  logic             i_trap,
    input  logic             i_mret,
    output logic             o_stall_pc,
    output logic             o_stall_ifid,
    output logic             o_stall_idex,
    output logic             o_stall_exmem,
    output logic             o_flush_ifid,
    output logic             o_flush_idex,
    output logic             o_flush_exmem,
    output logic             o_flush_memwb,
    output logic [1:0]       o_pc_sel,
    output logic             o_mem_fault
);

    localparam int              CNT_W    = (MAX_MEM_WAIT > 1) ? $clog2(MAX_MEM_WAIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_MEM_WAIT - 1);

    ctrl_state_e      state_r, state_nxt_s;
    logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
    logic             load_use_s;
    logic             stall_pc_s, stall_ifid_s, stall_idex_s, stall_exmem_s;
    logic             flush_ifid_s, flush_idex_s, flush_exmem_s, flush_memwb_s;
    logic [1:0]       pc_sel_s;
    logic             fault_s;

    // Load-use hazard: EX load writing a non-zero rd that the ID instruction reads.
    always_comb begin
        load_use_s = i_ex_is_load & i_ex_wr_en & (i_rd_addr_ex != 5'd0) &
                     (src_hit(i_rs1_used_id, i_rs1_addr_id, i_rd_addr_ex) |
                      src_hit(i_rs2_used_id, i_rs2_addr_id, i_rd_addr_ex));
    end

    // Strobe decode and next-state selection from current state and inputs.
    always_comb begin
        stall_pc_s    = 1'b0;
        stall_ifid_s  = 1'b0;
        stall_idex_s  = 1'b0;
        stall_exmem_s = 1'b0;
        flush_ifid_s  = 1'b0;
        flush_idex_s  = 1'b0;
        flush_exmem_s = 1'b0;
        flush_memwb_s = 1'b0;
        pc_sel_s      = PC_SEL_SEQ;
        fault_s       = 1'b0;
        state_nxt_s   = CTRL_RUN;
        cnt_nxt_s     = cnt_r;
        if (!i_rst_n) begin
            flush_ifid_s  = 1'b1;
            flush_idex_s  = 1'b1;
            flush_exmem_s = 1'b1;
            flush_memwb_s = 1'b1;
            cnt_nxt_s     = {CNT_W{1'b0}};
        end else begin
            case (state_r)
                CTRL_RUN, CTRL_REDIRECT: begin
                    // The fetch already in flight behind a redirect is wrong-path.
                    flush_ifid_s = (state_r == CTRL_REDIRECT);
                    if (i_trap | i_mret) begin
                        flush_ifid_s  = 1'b1;
                        flush_idex_s  = 1'b1;
                        flush_exmem_s = 1'b1;
                        pc_sel_s      = i_trap ? PC_SEL_TRAP : PC_SEL_MRET;
                        state_nxt_s   = CTRL_REDIRECT;
                    end else if (i_mem_req & ~i_mem_ack) begin
                        stall_pc_s    = 1'b1;
                        stall_ifid_s  = 1'b1;
                        stall_idex_s  = 1'b1;
                        stall_exmem_s = 1'b1;
                        flush_memwb_s = 1'b1;
                        cnt_nxt_s     = {CNT_W{1'b0}};
                        state_nxt_s   = CTRL_MEM_WAIT;
                    end else if (i_branch_taken) begin
                        flush_ifid_s  = 1'b1;
                        flush_idex_s  = 1'b1;
                        pc_sel_s      = PC_SEL_BR;
                        state_nxt_s   = CTRL_REDIRECT;
                    end else if (load_use_s & (state_r == CTRL_RUN)) begin
                        stall_pc_s    = 1'b1;
                        stall_ifid_s  = 1'b1;
                        flush_idex_s  = 1'b1;
                        state_nxt_s   = CTRL_RUN;
                    end else begin
                        state_nxt_s   = CTRL_RUN;
                    end
                end
                CTRL_MEM_WAIT: begin
                    if (i_mem_ack) begin
                        state_nxt_s   = CTRL_RUN;
                    end else if (cnt_r == CNT_LAST) begin
                        fault_s       = 1'b1;
                        flush_memwb_s = 1'b1;
                        state_nxt_s   = CTRL_RUN;
                    end else begin
                        stall_pc_s    = 1'b1;
                        stall_ifid_s  = 1'b1;
                        stall_idex_s  = 1'b1;
                        stall_exmem_s = 1'b1;
                        flush_memwb_s = 1'b1;
                        cnt_nxt_s     = cnt_r + 1'b1;
                        state_nxt_s   = CTRL_MEM_WAIT;
                    end
                end
                default: begin
                    state_nxt_s = CTRL_RUN;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                end
            endcase
        end
    end

    // A flush loads a bubble, so it wins over a hold on the same register.
    always_comb begin
        o_stall_pc    = stall_pc_s;
        o_stall_ifid  = stall_ifid_s  & ~flush_ifid_s;
        o_stall_idex  = stall_idex_s  & ~flush_idex_s;
        o_stall_exmem = stall_exmem_s & ~flush_exmem_s;
        o_flush_ifid  = flush_ifid_s;
        o_flush_idex  = flush_idex_s;
        o_flush_exmem = flush_exmem_s;
        o_flush_memwb = flush_memwb_s;
        o_pc_sel      = pc_sel_s;
        o_mem_fault   = fault_s;
    end

    // Controller state and memory-wait counter.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_r <= CTRL_RUN;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl with MAX_MEM_WAIT=4; expected strobe vectors hand-computed.
module tb_pipeline_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] rs1, rs2, rd;
    logic       rs1_used, rs2_used, ex_load, ex_wr, br, req, ack, trap, mret;
    logic       s_pc, s_ifid, s_idex, s_exmem, f_ifid, f_idex, f_exmem, f_memwb, fault;
    logic [1:0] pc_sel;
    int         checks = 0;
    int         errors = 0;

    pipeline_ctrl #(.MAX_MEM_WAIT(4)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_rs1_addr_id(rs1), .i_rs2_addr_id(rs2),
        .i_rs1_used_id(rs1_used), .i_rs2_used_id(rs2_used),
        .i_rd_addr_ex(rd), .i_ex_is_load(ex_load), .i_ex_wr_en(ex_wr),
        .i_branch_taken(br), .i_mem_req(req), .i_mem_ack(ack),
        .i_trap(trap), .i_mret(mret),
        .o_stall_pc(s_pc), .o_stall_ifid(s_ifid), .o_stall_idex(s_idex), .o_stall_exmem(s_exmem),
        .o_flush_ifid(f_ifid), .o_flush_idex(f_idex), .o_flush_exmem(f_exmem), .o_flush_memwb(f_memwb),
        .o_pc_sel(pc_sel), .o_mem_fault(fault)
    );

    always #5 clk = ~clk;

    initial begin
        #20000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    // Vector layout: {stall pc,ifid,idex,exmem}_{flush ifid,idex,exmem,memwb}_{pc_sel}_{fault}
    task automatic cyc(input string tag, input logic [10:0] exp);
        logic [10:0] obs;
        #2;
        obs = {s_pc, s_ifid, s_idex, s_exmem, f_ifid, f_idex, f_exmem, f_memwb, pc_sel, fault};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0;
        rs1_used = 1'b0; rs2_used = 1'b0; ex_load = 1'b0; ex_wr = 1'b0;
        br = 1'b0; req = 1'b0; ack = 1'b0; trap = 1'b0; mret = 1'b0;
    endtask

    task automatic set_load_use();
        ex_load = 1'b1; ex_wr = 1'b1; rd = 5'd5; rs1 = 5'd5; rs1_used = 1'b1;
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        req = 1'b1;
        cyc("reset0", 11'b0000_1111_00_0);
        cyc("reset1", 11'b0000_1111_00_0);
        rst_n = 1'b1;
        idle_inputs();
        cyc("idle", 11'b0000_0000_00_0);

        // Load-use and its non-hazard variants
        set_load_use();
        cyc("lu_rs1", 11'b1100_0100_00_0);
        idle_inputs();
        cyc("lu_after", 11'b0000_0000_00_0);
        set_load_use(); rd = 5'd0; rs1 = 5'd0;
        cyc("lu_x0", 11'b0000_0000_00_0);
        set_load_use(); rs1_used = 1'b0;
        cyc("lu_unused", 11'b0000_0000_00_0);
        set_load_use(); rs1 = 5'd6; rs2 = 5'd5; rs2_used = 1'b1;
        cyc("lu_rs2", 11'b1100_0100_00_0);
        set_load_use(); ex_wr = 1'b0;
        cyc("lu_nowr", 11'b0000_0000_00_0);
        idle_inputs();

        // Timeout: 1 RUN + 3 MEM_WAIT stall cycles, then one fault cycle
        req = 1'b1;
        cyc("to_run", 11'b1111_0001_00_0);
        cyc("to_w1", 11'b1111_0001_00_0);
        cyc("to_w2", 11'b1111_0001_00_0);
        cyc("to_w3", 11'b1111_0001_00_0);
        cyc("to_fault", 11'b0000_0001_00_1);
        req = 1'b0;
        cyc("to_after", 11'b0000_0000_00_0);

        // Ack on the 3rd MEM_WAIT cycle, then a fresh wait must start counting from zero
        req = 1'b1;
        cyc("ak_run", 11'b1111_0001_00_0);
        cyc("ak_w1", 11'b1111_0001_00_0);
        cyc("ak_w2", 11'b1111_0001_00_0);
        ack = 1'b1;
        cyc("ak_w3", 11'b0000_0000_00_0);
        ack = 1'b0;
        cyc("ak2_run", 11'b1111_0001_00_0);
        cyc("ak2_w1", 11'b1111_0001_00_0);
        cyc("ak2_w2", 11'b1111_0001_00_0);
        cyc("ak2_w3", 11'b1111_0001_00_0);
        cyc("ak2_fault", 11'b0000_0001_00_1);
        ack = 1'b1;
        cyc("zero_wait", 11'b0000_0000_00_0);
        idle_inputs();

        // Branch beats load-use; redirect cleanup next cycle
        set_load_use(); br = 1'b1;
        cyc("br_lu", 11'b0000_1100_01_0);
        idle_inputs();
        set_load_use();
        cyc("br_redir", 11'b0000_1000_00_0);
        idle_inputs();
        cyc("br_idle", 11'b0000_0000_00_0);

        // Trap beats branch and memory wait; mret inside REDIRECT re-enters it
        trap = 1'b1; br = 1'b1; req = 1'b1;
        cyc("trap_all", 11'b0000_1110_10_0);
        idle_inputs(); mret = 1'b1;
        cyc("mret_redir", 11'b0000_1110_11_0);
        idle_inputs();
        cyc("redir_clr", 11'b0000_1000_00_0);
        mret = 1'b1;
        cyc("mret_run", 11'b0000_1110_11_0);
        mret = 1'b0; req = 1'b1;
        cyc("redir_req", 11'b1011_1001_00_0);
        ack = 1'b1;
        cyc("redir_ack", 11'b0000_0000_00_0);
        idle_inputs();

        // Reset during MEM_WAIT
        req = 1'b1;
        cyc("rw_run", 11'b1111_0001_00_0);
        cyc("rw_w1", 11'b1111_0001_00_0);
        rst_n = 1'b0;
        cyc("rw_rst", 11'b0000_1111_00_0);
        rst_n = 1'b1; req = 1'b0;
        cyc("rw_rel0", 11'b0000_0000_00_0);
        cyc("rw_rel1", 11'b0000_0000_00_0);
        cyc("rw_rel2", 11'b0000_0000_00_0);

        // Reset during REDIRECT
        br = 1'b1;
        cyc("rr_br", 11'b0000_1100_01_0);
        br = 1'b0; rst_n = 1'b0;
        cyc("rr_rst", 11'b0000_1111_00_0);
        rst_n = 1'b1;
        cyc("rr_rel", 11'b0000_0000_00_0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
